// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC select (PC+4 / hold / branch redirect) plus IF/ID register.
// Latency: next is combinational (0 cycles); IF/ID and redirect_pending update at the following posedge.
// Backpressure: stall holds PC and IF/ID; a taken branch seen under stall is latched and replayed once stall drops.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   address, instr          current PC and its instruction-memory read data (same cycle)
//   stall                   hazard hold for PC and IF/ID
//   br_taken, br_target     resolved taken-branch pulse and its target
//   next                    next PC fed back to program_counter
//   ifid_pc/instr/valid     IF/ID pipeline register
//   redirect_pending        high while a deferred redirect is waiting for stall to clear
module fetch_stage #(
    parameter int unsigned      ADDR_W    = 64,
    parameter int unsigned      INSTR_W   = 32,
    parameter int unsigned      PC_INC    = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    output logic [ADDR_W-1:0]   next,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic                ifid_valid,
    output logic                redirect_pending
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pend_target, pend_target_nxt;
    logic [ADDR_W-1:0]   ifid_pc_nxt;
    logic [INSTR_W-1:0]  ifid_instr_nxt;
    logic                ifid_valid_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pend_target <= '0;
            ifid_pc     <= '0;
            ifid_instr  <= NOP_INSTR;
            ifid_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
            ifid_pc     <= ifid_pc_nxt;
            ifid_instr  <= ifid_instr_nxt;
            ifid_valid  <= ifid_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        ifid_pc_nxt     = ifid_pc;
        ifid_instr_nxt  = ifid_instr;
        ifid_valid_nxt  = ifid_valid;
        next            = address;

        if (reset) begin
            next      = '0;
            state_nxt = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (br_taken && !stall) begin
                        next           = br_target;
                        ifid_pc_nxt    = '0;
                        ifid_instr_nxt = NOP_INSTR;
                        ifid_valid_nxt = 1'b0;
                    end else if (br_taken) begin
                        // Branch under stall: remember the target, squash the
                        // wrong-path instruction now but keep its pc/instr bits.
                        next            = address;
                        pend_target_nxt = br_target;
                        ifid_valid_nxt  = 1'b0;
                        state_nxt       = PEND;
                    end else if (stall) begin
                        next = address;
                    end else begin
                        next           = address + INC;
                        ifid_pc_nxt    = address;
                        ifid_instr_nxt = instr;
                        ifid_valid_nxt = 1'b1;
                    end
                end
                PEND: begin
                    // Later br_taken pulses are younger wrong-path work; the
                    // first redirect wins, so br_taken is not looked at here.
                    if (stall) begin
                        next = address;
                    end else begin
                        next           = pend_target;
                        ifid_pc_nxt    = '0;
                        ifid_instr_nxt = NOP_INSTR;
                        ifid_valid_nxt = 1'b0;
                        state_nxt      = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign redirect_pending = (state == PEND);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic [31:0] instr;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] next;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        redirect_pending;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .address          (address),
        .instr            (instr),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .next             (next),
        .ifid_pc          (ifid_pc),
        .ifid_instr       (ifid_instr),
        .ifid_valid       (ifid_valid),
        .redirect_pending (redirect_pending)
    );

    // Reference model: the program counter, the IF/ID contents, and a queue of
    // deferred redirects (at most one entry: only the first one is kept).
    logic [63:0] pc_m;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [63:0] pend_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational next, clock, check IF/ID.
    task automatic step(input logic rst, input logic st, input logic bt,
                        input logic [63:0] tgt, input logic [31:0] ins);
        logic [63:0] exp_next;
        @(negedge clk);
        reset     = rst;
        stall     = st;
        br_taken  = bt;
        br_target = tgt;
        address   = pc_m;
        instr     = ins;
        #1;
        if (rst)                 exp_next = 64'd0;
        else if (st)             exp_next = pc_m;
        else if (pend_q.size())  exp_next = pend_q[0];
        else if (bt)             exp_next = tgt;
        else                     exp_next = pc_m + 64'd4;
        check("next", next, exp_next);

        if (rst) begin
            pend_q.delete();
            m_pc = 0; m_instr = NOP; m_valid = 0;
        end else if (pend_q.size() != 0) begin
            if (!st) begin
                void'(pend_q.pop_front());
                m_pc = 0; m_instr = NOP; m_valid = 0;
            end
        end else if (bt) begin
            if (st) begin
                pend_q.push_back(tgt);
                m_valid = 0;
            end else begin
                m_pc = 0; m_instr = NOP; m_valid = 0;
            end
        end else if (!st) begin
            m_pc = pc_m; m_instr = ins; m_valid = 1;
        end
        pc_m = exp_next;

        @(posedge clk);
        #1;
        check("ifid_pc", ifid_pc, m_pc);
        check("ifid_instr", {32'd0, ifid_instr}, {32'd0, m_instr});
        check("ifid_valid", {63'd0, ifid_valid}, {63'd0, m_valid});
        check("redirect_pending", {63'd0, redirect_pending}, {63'd0, pend_q.size() != 0});
    endtask

    initial begin
        reset = 1; stall = 0; br_taken = 0; br_target = 0; address = 0; instr = 0;
        pc_m = 0; m_pc = 0; m_instr = NOP; m_valid = 0;

        // 1: reset then three sequential fetches
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'hAAAA_0001);
        step(0, 0, 0, 0, 32'hBBBB_0002);
        step(0, 0, 0, 0, 32'hCCCC_0003);
        check("t1_pc_after_3", pc_m, 64'd12);

        // 2: taken branch without stall at 0x10
        pc_m = 64'h10;
        step(0, 0, 1, 64'h200, 32'h1111_1111);
        check("t2_bubble_valid", {63'd0, ifid_valid}, 64'd0);
        step(0, 0, 0, 0, 32'h2222_2222);
        check("t2_fetch_pc", ifid_pc, 64'h200);

        // 3: two stall cycles at 0x20
        pc_m = 64'h20;
        step(0, 1, 0, 0, 32'h3333_3333);
        step(0, 1, 0, 0, 32'h3333_3333);
        step(0, 0, 0, 0, 32'h3333_3333);
        check("t3_resume", pc_m, 64'h24);

        // 4: branch under stall, second branch ignored, redirect replayed
        step(0, 1, 1, 64'h400, 32'h4444_4444);
        step(0, 1, 1, 64'h800, 32'h4444_4445);
        step(0, 0, 0, 0, 32'h4444_4446);
        check("t4_redirect", pc_m, 64'h400);

        // 5: PC wraps mod 2^64
        pc_m = 64'hFFFF_FFFF_FFFF_FFFC;
        step(0, 0, 0, 0, 32'h5555_5555);
        check("t5_wrap", pc_m, 64'd0);

        // 6: reset while a redirect is pending
        step(0, 1, 1, 64'h900, 32'h6666_6666);
        step(1, 1, 0, 0, 32'h6666_6667);
        step(0, 0, 0, 0, 32'h6666_6668);
        check("t6_restart_pc", ifid_pc, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] tgt;
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0,
                 tgt, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
